// File: rtl/apb_tb_pkg.sv
// Shared definitions for the APB completer model: FSM encoding, bus defaults,
// wait-state LFSR taps and a constant log2 helper.
package apb_tb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [15:0] DEFAULT_RDATA = 16'hABCD;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // ceil(log2(v)); v <= 1 returns 0
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_wait_lfsr.sv
// 16-bit Galois LFSR used to draw pseudo-random wait-state counts.
// The whole state is exposed so a bench can track the sequence.
module apb_wait_lfsr
  import apb_tb_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] state
);

  // One Galois step per advance; synchronous reset reloads the seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (advance) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/apb_completer_model.sv
// Cycle-accurate APB completer with NUM_SEL byte-strobed register windows,
// fixed or LFSR-driven wait states and deterministic slave-error reporting.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for a setup phase (psel set, penable low)
//   ACCESS | transfer captured; counting waits, completes when cnt == 0
module apb_completer_model
  import apb_tb_pkg::*;
#(
  parameter int          NUM_SEL       = 2,
  parameter int          ADDR_W        = 20,
  parameter int          DATA_W        = 16,
  parameter int          DEPTH         = 64,
  parameter logic [DATA_W-1:0] DEFAULT_RDATA = 16'hABCD,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SEL-1:0]    psel,
  input  logic                  penable,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic                  pwrite,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  input  logic                  wait_mode,
  input  logic [3:0]            wait_max,
  input  logic                  err_force,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int BW     = clog2(STRB_W);
  localparam int AW     = clog2(DEPTH);
  localparam int SW     = (NUM_SEL > 1) ? clog2(NUM_SEL) : 1;

  state_t                state;
  logic [NUM_SEL-1:0]    sel_vec;
  logic [SW-1:0]         sel_idx;
  logic [AW-1:0]         word_idx;
  logic                  dec_err;
  logic [3:0]            cnt;
  logic                  err_pending;

  logic [DATA_W-1:0]     mem [NUM_SEL][DEPTH];

  logic [15:0]           lfsr_state;
  logic                  setup;
  logic                  psel_onehot;
  logic [SW-1:0]         low_idx;
  logic                  high_addr;
  logic                  abort;
  logic                  complete;
  logic                  xfer_err;
  logic [3:0]            wait_cnt;
  logic                  unused_bits;

  assign unused_bits = ^{lfsr_state[15:4], paddr};

  apb_wait_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (setup),
    .state   (lfsr_state)
  );

  assign setup       = (state == IDLE) && (|psel) && !penable;
  assign psel_onehot = (psel != '0) && ((psel & (psel - NUM_SEL'(1))) == '0);
  assign high_addr   = (paddr[ADDR_W-1:AW+BW] != '0);
  assign wait_cnt    = wait_mode ? (lfsr_state[3:0] & wait_max) : wait_max;

  // Index of the lowest asserted psel bit; only meaningful when one-hot.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_SEL - 1; i >= 0; i--) begin
      if (psel[i]) low_idx = SW'(i);
    end
  end

  // Any change of the select vector during access abandons the transfer.
  assign abort    = (state == ACCESS) && (psel != sel_vec);
  assign complete = (state == ACCESS) && !abort && penable && (cnt == 4'd0);
  assign xfer_err = dec_err | err_pending;

  // pready/prdata must be valid in the completing cycle itself, so they are
  // decoded from the registered state rather than registered again.
  assign pready  = complete;
  assign pslverr = complete & xfer_err;
  assign prdata  = (complete && !pwrite && !xfer_err) ? mem[sel_idx][word_idx]
                                                      : DEFAULT_RDATA;

  // Transfer sequencing: capture on setup, down-count waits, leave on
  // completion or abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sel_vec  <= '0;
      sel_idx  <= '0;
      word_idx <= '0;
      dec_err  <= 1'b0;
      cnt      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            sel_vec  <= psel;
            sel_idx  <= low_idx;
            word_idx <= paddr[AW+BW-1:BW];
            dec_err  <= high_addr || !psel_onehot;
            cnt      <= wait_cnt;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (abort) begin
            state <= IDLE;
          end else if (penable) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky forced error; a pulse coinciding with a completion is kept for
  // the next transfer rather than being consumed by the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pending <= 1'b0;
    end else if (err_force) begin
      err_pending <= 1'b1;
    end else if (complete) begin
      err_pending <= 1'b0;
    end
  end

  // Window storage: cleared on reset, byte-strobed writes on clean completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SEL; s++) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem[s][w] <= '0;
        end
      end
    end else if (complete && pwrite && !xfer_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (pstrb[b]) mem[sel_idx][word_idx][b*8 +: 8] <= pwdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: doc/apb_completer_model.md
Name: apb_completer_model

Overview:
- Parametrised, cycle-accurate APB completer model for the SPI/crypto test benches; the successor to the fixed-random APB responder.
- Backs NUM_SEL independent register windows with byte-strobed storage.
- Inserts fixed or pseudo-random wait states and flags slave errors deterministically (decode, multi-select, forced injection).
- Sits on the bench APB bus in parallel with the DUT so that the scoreboard compares prdata/pready/pslverr.

Parameters:
- NUM_SEL, 2: number of psel lines / register windows.
- ADDR_W, 20: paddr width.
- DATA_W, 16: data width; multiple of 8.
- DEPTH, 64: words per window; power of two.
- DEFAULT_RDATA, 16'hABCD: prdata value whenever no read is completing.
- LFSR_SEED, 16'hACE1: wait-state LFSR reset value; nonzero.

Ports:
- clk  in  1  bench clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- psel  in  NUM_SEL  one-hot window select.
- penable  in  1  APB access phase.
- paddr  in  ADDR_W  byte address.
- pwrite  in  1  1 = write.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  byte write strobes.
- wait_mode  in  1  0 = fixed waits; 1 = LFSR-random waits.
- wait_max  in  4  fixed wait count, or random mask (waits = lfsr[3:0] & wait_max).
- err_force  in  1  force pslverr on the next completed transfer.
- prdata  out  DATA_W  read data.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error, valid only with pready.

Behaviour:
- Reset (synchronous, active-high, dominant over every other event):
  - state = IDLE, prdata = DEFAULT_RDATA, pready = 0, pslverr = 0.
  - All storage = 0, LFSR = LFSR_SEED, err_pending = 0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On |psel && !penable (setup), capture the following, then go to ACCESS:
    - sel index.
    - word index = paddr[AW+BW-1:BW], where BW = log2(DATA_W/8) and AW = log2(DEPTH).
    - decode error = (paddr[ADDR_W-1:AW+BW] != 0) or psel not one-hot.
    - cnt = wait_mode ? (lfsr[3:0] & wait_max) : wait_max.
  - The LFSR advances exactly once per setup capture.
- ACCESS:
  - Exit to IDLE with no storage update when psel drops or the selected psel bit changes (abort).
  - penable high, cnt != 0: cnt decrements each cycle; pready = 0.
  - penable high, cnt == 0: pready = 1 (combinational from state and cnt); the transfer completes; next state is IDLE.
  - A setup phase in the same cycle as completion is not accepted; a back-to-back setup is recognised in the following cycle, per APB.
- Zero-wait: wait_max = 0 gives pready in the first access cycle (2-cycle transfer). N waits give an N+2-cycle transfer.
- Completion, write, no error: a byte is written for each pstrb bit set. pstrb = 0 writes nothing but still completes OKAY.
- Completion, read, no error: prdata = stored word, driven only in the completing cycle. At all other times prdata = DEFAULT_RDATA.
- Error: pslverr = decode error OR err_pending.
  - On error, no write occurs and prdata = DEFAULT_RDATA.
  - err_pending is set by an err_force pulse in any state and cleared at the next completion.
- Width rules:
  - Storage is DEPTH x DATA_W per window.
  - Reads ignore pstrb.
  - Address bits below BW are ignored (word-aligned).

Decomposition:
- Package apb_tb_pkg:
  - FSM state encoding (IDLE = 1'b0, ACCESS = 1'b1).
  - DEFAULT_RDATA constant.
  - LFSR tap mask 16'hB400 (x^16+x^14+x^13+x^11+1).
  - Function clog2.
- Sub-module apb_wait_lfsr:
  - 16-bit Galois LFSR with an advance enable, seed parameter and synchronous reset to seed.
  - Exposes the full state so that the bench can predict it.

Test Plan:
- Fixed zero-wait write then read: wait_mode = 0, wait_max = 0; write psel = 01, paddr = 0x00004, pwdata = 16'h1234, pstrb = 2'b11; then read the same address -> pready in the 2nd cycle of each transfer, prdata = 16'h1234, pslverr = 0.
- Strobe and window isolation: write 16'hFFFF, then pstrb = 2'b01 pwdata = 16'h00AA to psel = 10 addr 0x2; read back -> 16'hFFAA. The same address under psel = 01 reads 16'h0000.
- Wait states: wait_max = 3 -> pready low for 3 access cycles, high on the 4th.
  - wait_mode = 1, wait_max = 4'hF, after reset -> the first wait count equals LFSR_SEED[3:0] & 4'hF = 1.
- Errors, each with no storage change and prdata = 16'hABCD:
  - paddr = 0x00080 (beyond DEPTH) -> pslverr = 1 with pready.
  - psel = 11 -> pslverr = 1.
  - err_force pulse, then a valid read -> pslverr = 1 on that read only; the following read is OKAY.
- Abort and reset mid-transfer:
  - psel dropped during the wait with wait_max = 5 -> FSM returns to IDLE; the write is not committed.
  - reset asserted at cnt = 2 -> the next cycle shows pready = 0, prdata = 16'hABCD, and the memory reads 0.
- Back-to-back: 4 consecutive zero-wait writes without an idle cycle -> each completes in 2 cycles, and all 4 values read back correctly.
